// File: rtl/vco_table_sequencer.sv
// vco_table_sequencer: loads the vco sin/cos tables from a config stream and gates voltage bursts into the vco
module vco_table_sequencer #(
  parameter int VCO_BIT_WIDTH = 16,
  parameter int SIN_COS_ADDR_BIT_WIDTH = 11,
  parameter int IQ_BIT_WIDTH = 8,
  parameter int CNT_BIT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              table_load_start,
  input  logic [IQ_BIT_WIDTH-1:0]           table_cos_in,
  input  logic [IQ_BIT_WIDTH-1:0]           table_sin_in,
  input  logic                              table_in_valid,
  output logic                              table_in_ready,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0] cos_table_write_address,
  output logic [IQ_BIT_WIDTH-1:0]           cos_table_write_data,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0] sin_table_write_address,
  output logic [IQ_BIT_WIDTH-1:0]           sin_table_write_data,
  output logic                              table_ready,
  input  logic                              tx_start,
  input  logic [VCO_BIT_WIDTH-1:0]          voltage_in,
  input  logic                              voltage_in_valid,
  input  logic                              voltage_in_valid_last,
  output logic                              voltage_in_ready,
  output logic [VCO_BIT_WIDTH-1:0]          voltage_signal,
  output logic                              voltage_signal_valid,
  output logic                              voltage_signal_valid_last,
  input  logic                              sin_cos_out_valid_last,
  output logic                              tx_done,
  output logic [CNT_BIT_WIDTH-1:0]          sample_count,
  output logic                              busy,
  output logic                              proto_error
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, TX, DRAIN} state_t;
  state_t state, state_nx;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0] addr;
  logic load_pend, tbl_acc, v_acc, enter_load, err_set;
  assign tbl_acc = table_in_valid & table_in_ready;
  assign v_acc = voltage_in_valid & voltage_in_ready;
  // a start pulse inside LOAD restarts the table from address 0
  assign enter_load = (state_nx == LOAD) & ((state != LOAD) | table_load_start);
  assign err_set = ((state == IDLE) & tx_start) | ((state == READY) & tx_start & table_load_start) |
                   (((state == IDLE) | (state == READY)) & voltage_in_valid);
  assign sin_table_write_address = cos_table_write_address;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = table_load_start ? LOAD : IDLE;
      LOAD:    state_nx = (!table_load_start && tbl_acc && &addr) ? READY : LOAD;
      READY:   state_nx = table_load_start ? LOAD : tx_start ? TX : READY;
      TX:      state_nx = (v_acc && voltage_in_valid_last) ? DRAIN : TX;
      DRAIN:   state_nx = !sin_cos_out_valid_last ? DRAIN : (load_pend | table_load_start) ? LOAD : READY;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    table_in_ready = state == LOAD;
    voltage_in_ready = state == TX;
    busy = (state == LOAD) | (state == TX) | (state == DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      cos_table_write_address <= '0;
      cos_table_write_data <= '0;
      sin_table_write_data <= '0;
      table_ready <= 1'b0;
      proto_error <= 1'b0;
      load_pend <= 1'b0;
      voltage_signal <= '0;
      voltage_signal_valid <= 1'b0;
      voltage_signal_valid_last <= 1'b0;
      sample_count <= '0;
      tx_done <= 1'b0;
    end else begin
      addr <= enter_load ? '0 : tbl_acc ? addr + 1'b1 : addr;
      if (tbl_acc) begin
        cos_table_write_address <= addr;
        cos_table_write_data <= table_cos_in;
        sin_table_write_data <= table_sin_in;
      end
      table_ready <= enter_load ? 1'b0 : (state == LOAD && state_nx == READY) ? 1'b1 : table_ready;
      proto_error <= (proto_error & ~enter_load) | err_set;
      load_pend <= ((state == TX) | (state == DRAIN)) & (load_pend | table_load_start);
      if (v_acc) voltage_signal <= voltage_in;
      voltage_signal_valid <= v_acc;
      voltage_signal_valid_last <= v_acc & voltage_in_valid_last;
      sample_count <= (state == READY && state_nx == TX) ? '0 :
                      (v_acc && !(&sample_count)) ? sample_count + 1'b1 : sample_count;
      tx_done <= (state == DRAIN) & sin_cos_out_valid_last;
    end
  end
endmodule
